// File: rtl/path_backtrace_if.sv
// Bundle of the path_backtrace control, explored-RAM read port and path output stream.
// master: the backtrace engine; slave: the surrounding system (RAM mux, output stage).
interface path_backtrace_if;
  logic         start;
  logic [15:0]  goal_node_id;
  logic [15:0]  start_node_id;
  logic [271:0] read_node;
  logic [8:0]   read_address;
  logic         busy;
  logic         path_valid;
  logic         path_ready;
  logic [15:0]  path_node_id;
  logic [15:0]  path_x;
  logic [15:0]  path_y;
  logic         path_last;
  logic [8:0]   path_length;
  logic         done;
  logic         error;

  modport master (
    input  start, goal_node_id, start_node_id, read_node, path_ready,
    output read_address, busy, path_valid, path_node_id, path_x, path_y,
           path_last, path_length, done, error
  );

  modport slave (
    output start, goal_node_id, start_node_id, read_node, path_ready,
    input  read_address, busy, path_valid, path_node_id, path_x, path_y,
           path_last, path_length, done, error
  );
endinterface

// File: rtl/path_backtrace.sv
// path_backtrace: walks parent pointers from the goal node back to the start node by
// linearly scanning the explored-node RAM, emitting each node (goal first) on a
// valid/ready stream.
// node_info word layout: [15:0] node_id, [31:16] parent_node_id, [47:32] x, [63:48] y;
// bits above 63 are not used here.
// Optional build macro PATH_LOOP_GUARD_EN: ends the walk with error once path_length
// reaches MAX_NODES on a non-last beat (cyclic parent chains).
module path_backtrace #(
  parameter int MAX_NODES = 255
) (
  input  logic clk,
  input  logic reset,
  path_backtrace_if.master bus
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_SET_ADDRESS, ST_WAIT_READ, ST_READ, ST_EMIT, ST_NEXT_HOP, ST_DONE
  } state_e;

  localparam logic [8:0] LAST_ADDR = 9'(MAX_NODES - 1);
  localparam logic [8:0] LEN_MAX   = 9'd511;
  localparam logic [8:0] HOP_LIMIT = 9'(MAX_NODES);

  function automatic logic [15:0] node_id_f(input logic [271:0] w);
    return w[15:0];
  endfunction

  function automatic logic [15:0] parent_f(input logic [271:0] w);
    return w[31:16];
  endfunction

  function automatic logic [15:0] x_f(input logic [271:0] w);
    return w[47:32];
  endfunction

  function automatic logic [15:0] y_f(input logic [271:0] w);
    return w[63:48];
  endfunction

  state_e      state_q, state_d;
  logic [15:0] target_q, target_d;
  logic [15:0] end_id_q, end_id_d;
  logic [8:0]  read_address_q, read_address_d;
  logic        busy_q, busy_d;
  logic        path_valid_q, path_valid_d;
  logic [15:0] node_id_q, node_id_d;
  logic [15:0] parent_q, parent_d;
  logic [15:0] x_q, x_d;
  logic [15:0] y_q, y_d;
  logic        path_last_q, path_last_d;
  logic [8:0]  path_length_q, path_length_d;
  logic        done_q, done_d;
  logic        error_q, error_d;
  logic [8:0]  len_inc_s;
  logic        unused_read_bits_s;

  assign unused_read_bits_s = ^bus.read_node[271:64];
  assign len_inc_s = (path_length_q == LEN_MAX) ? path_length_q : path_length_q + 9'd1;

  assign bus.read_address = read_address_q;
  assign bus.busy         = busy_q;
  assign bus.path_valid   = path_valid_q;
  assign bus.path_node_id = node_id_q;
  assign bus.path_x       = x_q;
  assign bus.path_y       = y_q;
  assign bus.path_last    = path_last_q;
  assign bus.path_length  = path_length_q;
  assign bus.done         = done_q;
  assign bus.error        = error_q;

  // State and output registers with synchronous reset (mid-walk reset aborts silently).
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      target_q       <= 16'd0;
      end_id_q       <= 16'd0;
      read_address_q <= 9'd0;
      busy_q         <= 1'b0;
      path_valid_q   <= 1'b0;
      node_id_q      <= 16'd0;
      parent_q       <= 16'd0;
      x_q            <= 16'd0;
      y_q            <= 16'd0;
      path_last_q    <= 1'b0;
      path_length_q  <= 9'd0;
      done_q         <= 1'b0;
      error_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      target_q       <= target_d;
      end_id_q       <= end_id_d;
      read_address_q <= read_address_d;
      busy_q         <= busy_d;
      path_valid_q   <= path_valid_d;
      node_id_q      <= node_id_d;
      parent_q       <= parent_d;
      x_q            <= x_d;
      y_q            <= y_d;
      path_last_q    <= path_last_d;
      path_length_q  <= path_length_d;
      done_q         <= done_d;
      error_q        <= error_d;
    end
  end

  // Next-state logic: scan RAM for the current target, emit it, then hop to its parent.
  always_comb begin
    state_d        = state_q;
    target_d       = target_q;
    end_id_d       = end_id_q;
    read_address_d = read_address_q;
    busy_d         = busy_q;
    path_valid_d   = path_valid_q;
    node_id_d      = node_id_q;
    parent_d       = parent_q;
    x_d            = x_q;
    y_d            = y_q;
    path_last_d    = path_last_q;
    path_length_d  = path_length_q;
    done_d         = 1'b0;
    error_d        = error_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          target_d       = bus.goal_node_id;
          end_id_d       = bus.start_node_id;
          read_address_d = 9'd0;
          path_length_d  = 9'd0;
          error_d        = 1'b0;
          busy_d         = 1'b1;
          state_d        = ST_WAIT_READ;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SET_ADDRESS: begin
        read_address_d = read_address_q + 9'd1;
        state_d        = ST_WAIT_READ;
      end
      ST_WAIT_READ: begin
        state_d = ST_READ;
      end
      ST_READ: begin
        if (node_id_f(bus.read_node) == target_q) begin
          node_id_d    = node_id_f(bus.read_node);
          parent_d     = parent_f(bus.read_node);
          x_d          = x_f(bus.read_node);
          y_d          = y_f(bus.read_node);
          path_last_d  = (node_id_f(bus.read_node) == end_id_q) ||
                         (parent_f(bus.read_node) == 16'd0);
          path_valid_d = 1'b1;
          state_d      = ST_EMIT;
        end else if ((node_id_f(bus.read_node) == 16'd0) || (read_address_q == LAST_ADDR)) begin
          error_d = 1'b1;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_DONE;
        end else begin
          state_d = ST_SET_ADDRESS;
        end
      end
      ST_EMIT: begin
        if (path_valid_q && bus.path_ready) begin
          path_valid_d  = 1'b0;
          path_length_d = len_inc_s;
          if (path_last_q) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_DONE;
`ifdef PATH_LOOP_GUARD_EN
          end else if (len_inc_s >= HOP_LIMIT) begin
            error_d = 1'b1;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_DONE;
`endif
          end else begin
            state_d = ST_NEXT_HOP;
          end
        end else begin
          state_d = ST_EMIT;
        end
      end
      ST_NEXT_HOP: begin
        target_d       = parent_q;
        read_address_d = 9'd0;
        state_d        = ST_WAIT_READ;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d      = ST_IDLE;
        busy_d       = 1'b0;
        path_valid_d = 1'b0;
      end
    endcase
  end

`ifndef PATH_LOOP_GUARD_EN
  logic unused_hop_limit_s;
  assign unused_hop_limit_s = ^HOP_LIMIT;
`endif

endmodule
